mips_instr_encoder: RTL and testbench

Sequential instruction encoder and instruction-memory loader: the inverse of the main decoder. It accepts symbolic instruction descriptors (operation enum, register numbers, immediate, byte target address) over a valid/ready stream. It packs each descriptor into a 32-bit MIPS word, resolving PC-relative branch offsets and J-type target fields against its own running PC, and writes the words sequentially into instruction memory. It sits between the testbench/boot ROM host and the instruction memory write port, and is used to load programs before the core is released.

---
 rtl/mips_pkg.sv | 100 ++++++++++
 rtl/mips_instr_encoder_if.sv | 32 +++
 rtl/mips_instr_pack.sv | 88 ++++++++
 rtl/mips_instr_encoder.sv | 123 ++++++++++++
 tb/tb_mips_instr_encoder.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS instruction encoder and decoder.
//   op_e         symbolic operation carried on the descriptor stream
//   OPC_* / FN_* opcode and funct field values (also used by the decoder)
//   err_e        encoder error cause, reported on err_code
//   state_e      encoder session FSM states
//   instr_desc_t one symbolic instruction descriptor
//   enc_r/enc_i/enc_j  field packers for the three MIPS formats
package mips_pkg;

   typedef enum logic [4:0] {
      OP_ADD, OP_ADDU, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
      OP_SLL, OP_SRL, OP_SRA, OP_JR,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LW, OP_SW, OP_LB, OP_SB,
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGEZ,
      OP_J, OP_JAL
   } op_e;

   // Primary opcodes
   localparam logic [5:0] OPC_RTYPE  = 6'b000000;
   localparam logic [5:0] OPC_REGIMM = 6'b000001;
   localparam logic [5:0] OPC_J      = 6'b000010;
   localparam logic [5:0] OPC_JAL    = 6'b000011;
   localparam logic [5:0] OPC_BEQ    = 6'b000100;
   localparam logic [5:0] OPC_BNE    = 6'b000101;
   localparam logic [5:0] OPC_BLEZ   = 6'b000110;
   localparam logic [5:0] OPC_BGTZ   = 6'b000111;
   localparam logic [5:0] OPC_ADDI   = 6'b001000;
   localparam logic [5:0] OPC_ADDIU  = 6'b001001;
   localparam logic [5:0] OPC_SLTI   = 6'b001010;
   localparam logic [5:0] OPC_ANDI   = 6'b001100;
   localparam logic [5:0] OPC_ORI    = 6'b001101;
   localparam logic [5:0] OPC_XORI   = 6'b001110;
   localparam logic [5:0] OPC_LUI    = 6'b001111;
   localparam logic [5:0] OPC_LB     = 6'b100000;
   localparam logic [5:0] OPC_LW     = 6'b100011;
   localparam logic [5:0] OPC_SB     = 6'b101000;
   localparam logic [5:0] OPC_SW     = 6'b101011;

   // R-type funct codes
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   // bgez shares the REGIMM opcode; rt selects the condition
   localparam logic [4:0] RT_BGEZ = 5'b00001;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_BAD_OP   = 3'd1,
      ERR_BR_RANGE = 3'd2,
      ERR_J_REGION = 3'd3,
      ERR_MISALIGN = 3'd4,
      ERR_OVERFLOW = 3'd5
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE,
      ST_ERROR
   } state_e;

   // op is kept as raw bits so that out-of-range encodings can reach the
   // packer and be reported as BAD_OP instead of being lost in a cast.
   typedef struct packed {
      logic [4:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [15:0] imm;
      logic [31:0] target;
   } instr_desc_t;

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
      return {OPC_RTYPE, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] field);
      return {opc, field};
   endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if: descriptor stream plus instruction-memory write port.
//   s_valid/s_ready/s_last  descriptor handshake, s_last marks end of session
//   s_op..s_target          symbolic instruction descriptor fields
//   mem_wen/mem_addr/mem_wdata  sequential instruction-memory write
// master = host side (drives descriptors), slave = encoder side.
interface mips_instr_encoder_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  s_valid;
   logic                  s_ready;
   logic                  s_last;
   logic [4:0]            s_op;
   logic [4:0]            s_rs;
   logic [4:0]            s_rt;
   logic [4:0]            s_rd;
   logic [4:0]            s_shamt;
   logic [15:0]           s_imm;
   logic [31:0]           s_target;
   logic                  mem_wen;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;

   modport master (
      output s_valid, s_last, s_op, s_rs, s_rt, s_rd, s_shamt, s_imm, s_target,
      input  s_ready, mem_wen, mem_addr, mem_wdata
   );

   modport slave (
      input  s_valid, s_last, s_op, s_rs, s_rt, s_rd, s_shamt, s_imm, s_target,
      output s_ready, mem_wen, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mips_instr_pack.sv
// mips_instr_pack: purely combinational descriptor-to-word packer.
//   desc  symbolic instruction descriptor
//   pc    byte address the word will occupy
//   word  32-bit MIPS encoding (unused fields forced to 0)
//   err   BAD_OP / MISALIGN / BR_RANGE / J_REGION, or NONE
// Overflow is a property of the session, not the instruction, and is
// checked by the caller.
module mips_instr_pack
   import mips_pkg::*;
(
   input  instr_desc_t desc,
   input  logic [31:0] pc,
   output logic [31:0] word,
   output err_e        err
);

   logic [31:0] pc4;
   logic [31:0] diff;
   logic [31:0] br_off;
   logic        br_fits;
   logic        j_region_ok;
   logic        tgt_misalign;
   logic        is_branch;
   logic        is_jump;

   assign pc4  = pc + 32'd4;
   assign diff = desc.target - pc4;
   // Word offset relative to the delay-slot PC; it fits the 16-bit field
   // only when bits [31:15] are all copies of the sign.
   assign br_off  = $signed(diff) >>> 2;
   assign br_fits = (&br_off[31:15]) | ~(|br_off[31:15]);

   assign j_region_ok  = (desc.target[31:28] == pc4[31:28]);
   assign tgt_misalign = |desc.target[1:0];

   assign is_branch = desc.op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGEZ};
   assign is_jump   = desc.op inside {OP_J, OP_JAL};

   always_comb begin
      word = '0;
      err  = ERR_NONE;
      case (desc.op)
         OP_ADD:   word = enc_r(desc.rs, desc.rt, desc.rd, 5'd0, FN_ADD);
         OP_ADDU:  word = enc_r(desc.rs, desc.rt, desc.rd, 5'd0, FN_ADDU);
         OP_SUB:   word = enc_r(desc.rs, desc.rt, desc.rd, 5'd0, FN_SUB);
         OP_AND:   word = enc_r(desc.rs, desc.rt, desc.rd, 5'd0, FN_AND);
         OP_OR:    word = enc_r(desc.rs, desc.rt, desc.rd, 5'd0, FN_OR);
         OP_XOR:   word = enc_r(desc.rs, desc.rt, desc.rd, 5'd0, FN_XOR);
         OP_NOR:   word = enc_r(desc.rs, desc.rt, desc.rd, 5'd0, FN_NOR);
         OP_SLT:   word = enc_r(desc.rs, desc.rt, desc.rd, 5'd0, FN_SLT);
         OP_SLL:   word = enc_r(5'd0, desc.rt, desc.rd, desc.shamt, FN_SLL);
         OP_SRL:   word = enc_r(5'd0, desc.rt, desc.rd, desc.shamt, FN_SRL);
         OP_SRA:   word = enc_r(5'd0, desc.rt, desc.rd, desc.shamt, FN_SRA);
         OP_JR:    word = enc_r(desc.rs, 5'd0, 5'd0, 5'd0, FN_JR);
         OP_ADDI:  word = enc_i(OPC_ADDI,  desc.rs, desc.rt, desc.imm);
         OP_ADDIU: word = enc_i(OPC_ADDIU, desc.rs, desc.rt, desc.imm);
         OP_SLTI:  word = enc_i(OPC_SLTI,  desc.rs, desc.rt, desc.imm);
         OP_ANDI:  word = enc_i(OPC_ANDI,  desc.rs, desc.rt, desc.imm);
         OP_ORI:   word = enc_i(OPC_ORI,   desc.rs, desc.rt, desc.imm);
         OP_XORI:  word = enc_i(OPC_XORI,  desc.rs, desc.rt, desc.imm);
         OP_LUI:   word = enc_i(OPC_LUI,   5'd0,    desc.rt, desc.imm);
         OP_LW:    word = enc_i(OPC_LW,    desc.rs, desc.rt, desc.imm);
         OP_SW:    word = enc_i(OPC_SW,    desc.rs, desc.rt, desc.imm);
         OP_LB:    word = enc_i(OPC_LB,    desc.rs, desc.rt, desc.imm);
         OP_SB:    word = enc_i(OPC_SB,    desc.rs, desc.rt, desc.imm);
         OP_BEQ:   word = enc_i(OPC_BEQ,    desc.rs, desc.rt, br_off[15:0]);
         OP_BNE:   word = enc_i(OPC_BNE,    desc.rs, desc.rt, br_off[15:0]);
         OP_BLEZ:  word = enc_i(OPC_BLEZ,   desc.rs, 5'd0,    br_off[15:0]);
         OP_BGTZ:  word = enc_i(OPC_BGTZ,   desc.rs, 5'd0,    br_off[15:0]);
         OP_BGEZ:  word = enc_i(OPC_REGIMM, desc.rs, RT_BGEZ, br_off[15:0]);
         OP_J:     word = enc_j(OPC_J,   desc.target[27:2]);
         OP_JAL:   word = enc_j(OPC_JAL, desc.target[27:2]);
         default:  err  = ERR_BAD_OP;
      endcase

      // Alignment is judged before range/region: a misaligned target has no
      // meaningful word offset.
      if (is_branch) begin
         if (tgt_misalign)  err = ERR_MISALIGN;
         else if (!br_fits) err = ERR_BR_RANGE;
      end
      if (is_jump) begin
         if (tgt_misalign)      err = ERR_MISALIGN;
         else if (!j_region_ok) err = ERR_J_REGION;
      end
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: loads a program into instruction memory from a stream
// of symbolic descriptors.
//   clk, reset       clock, synchronous active-high reset
//   start            opens a session from IDLE or ERROR
//   base_addr        byte PC of memory word 0
//   bus (slave)      descriptor stream in, memory write port out
//   busy/done/err    LOAD state, one-cycle completion pulse, ERROR state
//   err_code         cause latched when the session failed
// Each accepted descriptor is written one cycle later at the next word
// address; the PC used for branch/jump resolution tracks the write address.
module mips_instr_encoder
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [31:0]                base_addr,
   mips_instr_encoder_if.slave        bus,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output err_e                       err_code
);

   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_e              state, state_nxt;
   // One extra bit so count can represent "memory full" (2**ADDR_WIDTH).
   logic [ADDR_WIDTH:0] count;
   logic [31:0]         pc;

   instr_desc_t         desc;
   logic [31:0]         pack_word;
   err_e                pack_err;
   err_e                acc_err;
   logic                accept;
   logic                clean;
   logic                start_ok;

   assign desc = '{op:     bus.s_op,
                   rs:     bus.s_rs,
                   rt:     bus.s_rt,
                   rd:     bus.s_rd,
                   shamt:  bus.s_shamt,
                   imm:    bus.s_imm,
                   target: bus.s_target};

   mips_instr_pack u_pack (
      .desc (desc),
      .pc   (pc),
      .word (pack_word),
      .err  (pack_err)
   );

   assign start_ok = start && ((state == ST_IDLE) || (state == ST_ERROR));
   assign accept   = (state == ST_LOAD) && bus.s_valid;
   // Overflow outranks every per-instruction error.
   assign acc_err  = count[ADDR_WIDTH] ? ERR_OVERFLOW : pack_err;
   assign clean    = accept && (acc_err == ERR_NONE);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.s_ready = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            bus.s_ready = 1'b1;
            busy        = 1'b1;
            if (accept) begin
               if (acc_err != ERR_NONE) state_nxt = ST_ERROR;
               else if (bus.s_last)     state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_ERROR: begin
            err = 1'b1;
            if (start) state_nxt = ST_LOAD;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count         <= '0;
         pc            <= '0;
         err_code      <= ERR_NONE;
         bus.mem_wen   <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         bus.mem_wen <= clean;
         if (start_ok) begin
            count    <= '0;
            pc       <= base_addr;
            err_code <= ERR_NONE;
         end else if (clean) begin
            bus.mem_addr  <= count[ADDR_WIDTH-1:0];
            bus.mem_wdata <= pack_word;
            count         <= count + CNT_ONE;
            pc            <= pc + 32'd4;
         end else if (accept) begin
            err_code <= acc_err;
         end
      end
   end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Testbench for mips_instr_encoder: table of single-instruction sessions,
// hand-written multi-cycle sequences and randomized sessions checked against
// an arithmetic reference encoder.
module tb_mips_instr_encoder;
   import mips_pkg::*;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   localparam int K_BAD = 0, K_R3 = 1, K_SH = 2, K_JR = 3, K_I = 4, K_LUI = 5;
   localparam int K_BR2 = 6, K_BR1 = 7, K_BGEZ = 8, K_J = 9;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] base_addr;
   logic        busy, done, err;
   err_e        err_code;

   int          errors = 0;
   int          checks = 0;
   int          m_count;
   logic [31:0] m_pc;

   mips_instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

   mips_instr_encoder #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] base;
      int          op, rs, rt, rd, sh, imm;
      logic [31:0] tgt;
      int          e;
      logic [31:0] w;
   } vec_t;

   vec_t vt[16];

   // Reference encoder: field values from the instruction tables, offsets
   // and regions from integer arithmetic. Returns {err, word}.
   function automatic logic [34:0] ref_enc(input int op, input int rs, input int rt,
                                           input int rd, input int sh, input int imm,
                                           input logic [31:0] tgt, input logic [31:0] pc);
      logic [31:0] pc4, w;
      int kind, opc, fn, off, rtf;
      pc4 = pc + 32'd4;
      kind = K_BAD; opc = 0; fn = 0;
      case (op)
         OP_ADD:   begin kind = K_R3;   fn  = 'h20; end
         OP_ADDU:  begin kind = K_R3;   fn  = 'h21; end
         OP_SUB:   begin kind = K_R3;   fn  = 'h22; end
         OP_AND:   begin kind = K_R3;   fn  = 'h24; end
         OP_OR:    begin kind = K_R3;   fn  = 'h25; end
         OP_XOR:   begin kind = K_R3;   fn  = 'h26; end
         OP_NOR:   begin kind = K_R3;   fn  = 'h27; end
         OP_SLT:   begin kind = K_R3;   fn  = 'h2a; end
         OP_SLL:   begin kind = K_SH;   fn  = 'h00; end
         OP_SRL:   begin kind = K_SH;   fn  = 'h02; end
         OP_SRA:   begin kind = K_SH;   fn  = 'h03; end
         OP_JR:    begin kind = K_JR;   fn  = 'h08; end
         OP_ADDI:  begin kind = K_I;    opc = 'h08; end
         OP_ADDIU: begin kind = K_I;    opc = 'h09; end
         OP_SLTI:  begin kind = K_I;    opc = 'h0a; end
         OP_ANDI:  begin kind = K_I;    opc = 'h0c; end
         OP_ORI:   begin kind = K_I;    opc = 'h0d; end
         OP_XORI:  begin kind = K_I;    opc = 'h0e; end
         OP_LUI:   begin kind = K_LUI;  opc = 'h0f; end
         OP_LW:    begin kind = K_I;    opc = 'h23; end
         OP_SW:    begin kind = K_I;    opc = 'h2b; end
         OP_LB:    begin kind = K_I;    opc = 'h20; end
         OP_SB:    begin kind = K_I;    opc = 'h28; end
         OP_BEQ:   begin kind = K_BR2;  opc = 'h04; end
         OP_BNE:   begin kind = K_BR2;  opc = 'h05; end
         OP_BLEZ:  begin kind = K_BR1;  opc = 'h06; end
         OP_BGTZ:  begin kind = K_BR1;  opc = 'h07; end
         OP_BGEZ:  begin kind = K_BGEZ; opc = 'h01; end
         OP_J:     begin kind = K_J;    opc = 'h02; end
         OP_JAL:   begin kind = K_J;    opc = 'h03; end
         default:  kind = K_BAD;
      endcase
      w = 32'(opc) << 26;
      case (kind)
         K_R3:  w = w | 32'(rs) << 21 | 32'(rt) << 16 | 32'(rd) << 11 | 32'(fn);
         K_SH:  w = w | 32'(rt) << 16 | 32'(rd) << 11 | 32'(sh) << 6 | 32'(fn);
         K_JR:  w = w | 32'(rs) << 21 | 32'(fn);
         K_I:   w = w | 32'(rs) << 21 | 32'(rt) << 16 | 32'(imm);
         K_LUI: w = w | 32'(rt) << 16 | 32'(imm);
         K_BR2, K_BR1, K_BGEZ: begin
            if (tgt % 4 != 0) return {3'd4, 32'd0};
            off = int'(tgt - pc4) / 4;
            if (off < -32768 || off > 32767) return {3'd2, 32'd0};
            rtf = (kind == K_BR2) ? rt : (kind == K_BGEZ) ? 1 : 0;
            w = w | 32'(rs) << 21 | 32'(rtf) << 16 | (32'(off) & 32'h0000FFFF);
         end
         K_J: begin
            if (tgt % 4 != 0) return {3'd4, 32'd0};
            if (tgt / 32'h10000000 != pc4 / 32'h10000000) return {3'd3, 32'd0};
            w = w | (tgt % 32'h10000000) / 4;
         end
         default: return {3'd1, 32'd0};
      endcase
      return {3'd0, w};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " mem_wen"},   32'(bus.mem_wen),   0);
      chk({tag, " mem_addr"},  32'(bus.mem_addr),  0);
      chk({tag, " mem_wdata"}, bus.mem_wdata,      0);
      chk({tag, " s_ready"},   32'(bus.s_ready),   0);
      chk({tag, " busy"},      32'(busy),          0);
      chk({tag, " done"},      32'(done),          0);
      chk({tag, " err"},       32'(err),           0);
      chk({tag, " err_code"},  32'(err_code),      0);
   endtask

   task automatic do_start(input logic [31:0] base);
      start = 1'b1;
      base_addr = base;
      tick();
      start = 1'b0;
      chk("start busy",     32'(busy),        1);
      chk("start s_ready",  32'(bus.s_ready), 1);
      chk("start err",      32'(err),         0);
      chk("start err_code", 32'(err_code),    0);
      m_count = 0;
      m_pc    = base;
   endtask

   task automatic drive(input int op, input int rs, input int rt, input int rd,
                        input int sh, input int imm, input logic [31:0] tgt, input bit last);
      bus.s_op     = 5'(op);
      bus.s_rs     = 5'(rs);
      bus.s_rt     = 5'(rt);
      bus.s_rd     = 5'(rd);
      bus.s_shamt  = 5'(sh);
      bus.s_imm    = 16'(imm);
      bus.s_target = tgt;
      bus.s_last   = last;
   endtask

   // Offers one descriptor in LOAD and checks the following cycle.
   task automatic send(input string tag, input int op, input int rs, input int rt,
                       input int rd, input int sh, input int imm, input logic [31:0] tgt,
                       input bit last, input int e, input logic [31:0] w);
      chk({tag, " s_ready"}, 32'(bus.s_ready), 1);
      drive(op, rs, rt, rd, sh, imm, tgt, last);
      bus.s_valid = 1'b1;
      tick();
      bus.s_valid = 1'b0;
      if (e == 0) begin
         chk({tag, " mem_wen"},   32'(bus.mem_wen),  1);
         chk({tag, " mem_addr"},  32'(bus.mem_addr), 32'(m_count));
         chk({tag, " mem_wdata"}, bus.mem_wdata,     w);
         chk({tag, " done"},      32'(done),         32'(last));
         chk({tag, " err"},       32'(err),          0);
         m_count++;
         m_pc = m_pc + 32'd4;
      end else begin
         chk({tag, " mem_wen"},  32'(bus.mem_wen), 0);
         chk({tag, " err"},      32'(err),         1);
         chk({tag, " err_code"}, 32'(err_code),    32'(e));
         chk({tag, " s_ready"},  32'(bus.s_ready), 0);
      end
   endtask

   task automatic send_ref(input string tag, input int op, input int rs, input int rt,
                           input int rd, input int sh, input int imm, input logic [31:0] tgt,
                           input bit last);
      logic [34:0] r;
      if (m_count == DEPTH) r = {3'd5, 32'd0};
      else                  r = ref_enc(op, rs, rt, rd, sh, imm, tgt, m_pc);
      send(tag, op, rs, rt, rd, sh, imm, tgt, last, int'(r[34:32]), r[31:0]);
   endtask

   initial begin
      //           base          op        rs  rt  rd  sh  imm     tgt           e  w
      vt[0]  = '{32'h0,        OP_ADDI,  0,  8,  0,  0,  5,      32'h0,        0, 32'h20080005};
      vt[1]  = '{32'h00400000, OP_J,     0,  0,  0,  0,  0,      32'h00400010, 0, 32'h08100004};
      vt[2]  = '{32'h0,        OP_BEQ,   1,  2,  0,  0,  0,      32'h00020004, 2, 32'h0};
      vt[3]  = '{32'h0,        OP_BNE,   3,  4,  0,  0,  0,      32'h00020000, 0, 32'h14647FFF};
      vt[4]  = '{32'h0,        OP_JR,    31, 7,  7,  7,  0,      32'h0,        0, 32'h03E00008};
      vt[5]  = '{32'h0,        OP_LUI,   5,  1,  9,  3,  'h1234, 32'h0,        0, 32'h3C011234};
      vt[6]  = '{32'h0,        OP_BGEZ,  2,  9,  0,  0,  0,      32'h10,       0, 32'h04410003};
      vt[7]  = '{32'h100,      OP_BLEZ,  4,  7,  0,  0,  0,      32'h0,        0, 32'h1880FFBF};
      vt[8]  = '{32'h0,        30,       1,  1,  1,  1,  1,      32'h0,        1, 32'h0};
      vt[9]  = '{32'h0,        OP_BEQ,   1,  1,  0,  0,  0,      32'h6,        4, 32'h0};
      vt[10] = '{32'h0,        OP_J,     0,  0,  0,  0,  0,      32'h30000002, 4, 32'h0};
      vt[11] = '{32'h0,        OP_SRA,   9,  3,  2,  31, 0,      32'h0,        0, 32'h000317C3};
      vt[12] = '{32'h0,        OP_SW,    29, 31, 0,  0,  'hFFFC, 32'h0,        0, 32'hAFBFFFFC};
      vt[13] = '{32'hFFFFFFFC, OP_JAL,   0,  0,  0,  0,  0,      32'h00000040, 0, 32'h0C000010};
      vt[14] = '{32'h0,        OP_BEQ,   0,  0,  0,  0,  0,      32'hFFFE0004, 0, 32'h10008000};
      vt[15] = '{32'h0,        31,       0,  0,  0,  0,  0,      32'h0,        1, 32'h0};

      reset = 1'b1; start = 1'b0; base_addr = '0;
      bus.s_valid = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 32'h0, 1'b0);
      tick(); tick();
      chk_reset("reset");
      reset = 1'b0;

      // s_valid outside LOAD must be ignored
      bus.s_valid = 1'b1;
      tick();
      bus.s_valid = 1'b0;
      chk("idle valid mem_wen", 32'(bus.mem_wen), 0);
      chk("idle valid busy",    32'(busy),        0);

      // Table: one-descriptor sessions
      for (int i = 0; i < 16; i++) begin
         do_start(vt[i].base);
         send($sformatf("vec%0d", i), vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh,
              vt[i].imm, vt[i].tgt, 1'b1, vt[i].e, vt[i].w);
         tick();
         if (vt[i].e == 0) begin
            chk($sformatf("vec%0d after done", i), 32'(done), 0);
            chk($sformatf("vec%0d idle busy", i),  32'(busy), 0);
         end else begin
            chk($sformatf("vec%0d err held", i),   32'(err), 1);
            chk($sformatf("vec%0d err busy", i),   32'(busy), 0);
         end
      end

      // Back-to-back descriptors, no bubbles
      do_start(32'h0);
      send("b2b add", OP_ADD, 1, 2, 3, 0, 0, 32'h0, 1'b0, 0, 32'h00221820);
      send("b2b sll", OP_SLL, 9, 5, 4, 2, 0, 32'h0, 1'b0, 0, 32'h00052080);
      send("b2b beq", OP_BEQ, 1, 2, 0, 0, 0, 32'h0, 1'b1, 0, 32'h1022FFFD);
      tick();
      chk("b2b idle done", 32'(done), 0);
      chk("b2b idle wen",  32'(bus.mem_wen), 0);

      // Jump then region error: only one write
      do_start(32'h00400000);
      send("j ok",      OP_J,   0, 0, 0, 0, 0, 32'h00400010, 1'b0, 0, 32'h08100004);
      send("jal region", OP_JAL, 0, 0, 0, 0, 0, 32'h10000000, 1'b1, 3, 32'h0);
      tick();
      chk("jal no write", 32'(bus.mem_wen), 0);
      chk("jal err held", 32'(err),         1);

      // Overflow at 2**AW words, then recovery from ERROR
      do_start(32'h0);
      for (int i = 0; i < DEPTH; i++)
         send_ref($sformatf("fill%0d", i), OP_ORI, i, i + 1, 0, 0, i * 3, 32'h0, 1'b0);
      send("overflow", OP_ADDI, 1, 1, 0, 0, 1, 32'h0, 1'b1, 5, 32'h0);
      do_start(32'h00001000);
      send_ref("recover", OP_BNE, 2, 3, 0, 0, 0, 32'h00000FF0, 1'b1);
      tick();

      // Reset the cycle after an accept
      do_start(32'h0);
      send_ref("pre-reset", OP_XORI, 7, 8, 0, 0, 'hABCD, 32'h0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset("mid reset");

      // Reset coincident with an accept drops the write
      do_start(32'h0);
      drive(OP_ADD, 1, 2, 3, 0, 0, 32'h0, 1'b0);
      bus.s_valid = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.s_valid = 1'b0;
      chk("reset drop wen",  32'(bus.mem_wen), 0);
      chk("reset drop busy", 32'(busy),        0);

      // Randomized sessions
      for (int s = 0; s < 40; s++) begin
         int n;
         logic [31:0] base;
         base = $urandom() & 32'hFFFFFFFC;
         if ($urandom_range(0, 4) == 0) base = 32'hFFFFFFF8;
         n = $urandom_range(1, DEPTH + 1);
         do_start(base);
         for (int i = 0; i < n; i++) begin
            int op, mode, off, gap;
            logic [31:0] pc4, tgt, rnd;
            logic [34:0] r;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               tick();
               chk("rnd gap wen", 32'(bus.mem_wen), 0);
            end
            op = ($urandom_range(0, 15) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29);
            pc4 = m_pc + 32'd4;
            mode = $urandom_range(0, 2);
            rnd = $urandom();
            if (mode == 0) begin
               off = $urandom_range(0, 80000) - 40000;
               tgt = pc4 + 32'(off * 4);
            end else if (mode == 1) begin
               tgt = (pc4 & 32'hF0000000) | (rnd & 32'h0FFFFFFC);
            end else begin
               tgt = rnd & 32'hFFFFFFFC;
            end
            if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            if (m_count == DEPTH) r = {3'd5, 32'd0};
            else r = ref_enc(op, $urandom_range(0, 31), 0, 0, 0, 0, 32'h0, 32'h0);
            send_ref($sformatf("rnd s%0d i%0d", s, i), op, $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 65535), tgt, i == n - 1);
            if (err) break;
         end
         tick();
         if (err) begin
            bus.s_valid = 1'b1;
            tick();
            bus.s_valid = 1'b0;
            chk("rnd err ignores valid", 32'(bus.mem_wen), 0);
         end else begin
            chk("rnd idle done", 32'(done), 0);
            chk("rnd idle busy", 32'(busy), 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
